// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared constants and types for the register-file
// write arbiter.
//   ADDR_LEN / DATA_LEN : default register address / write data widths
//   RF_ZERO_ADDR        : hard-wired zero register (writes to it are dropped)
//   pick_t              : one arbiter pick (valid + requester index)
//   rr_next()           : round-robin pointer advance with wrap
package rf_write_arbiter_pkg;

  localparam int ADDR_LEN     = 5;
  localparam int DATA_LEN     = 32;
  localparam int RF_ZERO_ADDR = 0;

  // Wide enough for the largest supported requester count (8).
  localparam int PICK_IDX_W = 3;

  typedef struct packed {
    logic                  vld;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // Slot after the last granted one, wrapping at n.
  function automatic int rr_next(input int last, input int n);
    return (last + 1) % n;
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: writeback request bus plus the two RAM write ports.
//   req_valid_i/req_addr_i/req_data_i : per-requester requests (flattened,
//                                       requester i at [i*W +: W])
//   req_ready_o                       : per-requester accept
//   we1_o/waddr1_o/wdata1_o           : RAM write port 1
//   we2_o/waddr2_o/wdata2_o           : RAM write port 2
//   busy_o                            : any pending entry held
// master = requesters / RAM side, slave = arbiter.
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_LEN,
  parameter int DATA_W  = DATA_LEN
);
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      we1_o;
  logic [ADDR_W-1:0]         waddr1_o;
  logic [DATA_W-1:0]         wdata1_o;
  logic                      we2_o;
  logic [ADDR_W-1:0]         waddr2_o;
  logic [DATA_W-1:0]         wdata2_o;
  logic                      busy_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i,
    input  req_ready_o, we1_o, waddr1_o, wdata1_o,
           we2_o, waddr2_o, wdata2_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i,
    output req_ready_o, we1_o, waddr1_o, wdata1_o,
           we2_o, waddr2_o, wdata2_o, busy_o
  );
endinterface

// File: rtl/rf_wr_rr_picker.sv
// rf_wr_rr_picker: combinational round-robin selector for up to two
// pending entries per cycle.
//   pend_v    : pending-entry valid bits
//   pend_addr : flattened pending addresses (entry i at [i*ADDR_W +: ADDR_W])
//   rr_ptr    : scan start position
//   pick_a    : first valid entry in scan order
//   pick_b    : next valid entry whose address differs from pick_a's
//   grant     : one-hot-or-two-hot grant vector (pick_a | pick_b)
module rf_wr_rr_picker
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ADDR_LEN,
  parameter int PTR_W   = $clog2(NUM_REQ)
)(
  input  logic [NUM_REQ-1:0]        pend_v,
  input  logic [NUM_REQ*ADDR_W-1:0] pend_addr,
  input  logic [PTR_W-1:0]          rr_ptr,
  output pick_t                     pick_a,
  output pick_t                     pick_b,
  output logic [NUM_REQ-1:0]        grant
);

  logic [PTR_W-1:0]  idx;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] a_addr;

  always_comb begin
    pick_a   = '0;
    pick_b   = '0;
    grant    = '0;
    idx      = '0;
    cur_addr = '0;
    a_addr   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx      = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      cur_addr = pend_addr[int'(idx)*ADDR_W +: ADDR_W];
      if (pend_v[idx]) begin
        if (!pick_a.vld) begin
          pick_a.vld = 1'b1;
          pick_a.idx = PICK_IDX_W'(idx);
          a_addr     = cur_addr;
          grant[idx] = 1'b1;
        end else if (!pick_b.vld && cur_addr != a_addr) begin
          // Same-address entries behind A are skipped so the two RAM ports
          // never target one register in the same cycle.
          pick_b.vld = 1'b1;
          pick_b.idx = PICK_IDX_W'(idx);
          grant[idx] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the two register-file RAM write ports among
// NUM_REQ writeback requesters, each with a 1-entry pending buffer.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   flush_i : synchronous discard of all pending entries
//   wb      : request bus, RAM write ports and busy (rf_write_arbiter_if.slave)
// Request accepted at edge N is pending in N+1, can be granted in N+1 and
// appears on the registered write port during N+2.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = ADDR_LEN,
  parameter int DATA_W    = DATA_LEN,
  parameter int DROP_ZERO = 1
)(
  input logic               clk_i,
  input logic               rst_i,
  input logic               flush_i,
  rf_write_arbiter_if.slave wb
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             pend_v;
  logic [NUM_REQ-1:0][ADDR_W-1:0] pend_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] pend_data;
  logic [PTR_W-1:0]               rr_ptr;

  pick_t              pick_a, pick_b;
  logic [NUM_REQ-1:0] grant, ready, accept;
  logic [PTR_W-1:0]   a_idx, b_idx, last_idx;
  logic               a_zero, b_zero, a_wr, b_wr;

  logic              we1_q, we2_q;
  logic [ADDR_W-1:0] waddr1_q, waddr2_q;
  logic [DATA_W-1:0] wdata1_q, wdata2_q;

  rf_wr_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .PTR_W   (PTR_W)
  ) u_picker (
    .pend_v    (pend_v),
    .pend_addr (pend_addr),
    .rr_ptr    (rr_ptr),
    .pick_a    (pick_a),
    .pick_b    (pick_b),
    .grant     (grant)
  );

  assign a_idx    = PTR_W'(pick_a.idx);
  assign b_idx    = PTR_W'(pick_b.idx);
  assign last_idx = pick_b.vld ? b_idx : a_idx;

  // Zero-register entries retire through a pick but never raise we.
  assign a_zero = (DROP_ZERO != 0) && (pend_addr[a_idx] == ADDR_W'(RF_ZERO_ADDR));
  assign b_zero = (DROP_ZERO != 0) && (pend_addr[b_idx] == ADDR_W'(RF_ZERO_ADDR));
  assign a_wr   = pick_a.vld && !a_zero;
  assign b_wr   = pick_b.vld && !b_zero;

  // Ready depends only on registered state, flush and reset, so there is no
  // path from the request inputs to any output. A granted slot frees up in
  // the same cycle, giving one write per requester per cycle.
  assign ready  = (~pend_v | grant) & {NUM_REQ{~(rst_i | flush_i)}};
  assign accept = wb.req_valid_i & ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_v    <= '0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush_i) begin
          pend_v[i] <= 1'b0;
        end else if (accept[i]) begin
          pend_v[i]    <= 1'b1;
          pend_addr[i] <= wb.req_addr_i[i*ADDR_W +: ADDR_W];
          pend_data[i] <= wb.req_data_i[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          pend_v[i] <= 1'b0;
        end
      end
    end
  end

  // Write ports and scheduler pointer. Flush discards this cycle's picks
  // and leaves the pointer where it is; addr/data hold when not writing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      we1_q    <= 1'b0;
      waddr1_q <= '0;
      wdata1_q <= '0;
      we2_q    <= 1'b0;
      waddr2_q <= '0;
      wdata2_q <= '0;
    end else begin
      we1_q <= 1'b0;
      we2_q <= 1'b0;
      if (!flush_i) begin
        if (a_wr) begin
          we1_q    <= 1'b1;
          waddr1_q <= pend_addr[a_idx];
          wdata1_q <= pend_data[a_idx];
        end
        if (b_wr) begin
          we2_q    <= 1'b1;
          waddr2_q <= pend_addr[b_idx];
          wdata2_q <= pend_data[b_idx];
        end
        if (pick_a.vld)
          rr_ptr <= PTR_W'(rr_next(int'(last_idx), NUM_REQ));
      end
    end
  end

  assign wb.req_ready_o = ready;
  assign wb.we1_o       = we1_q;
  assign wb.waddr1_o    = waddr1_q;
  assign wb.wdata1_o    = wdata1_q;
  assign wb.we2_o       = we2_q;
  assign wb.waddr2_o    = waddr2_q;
  assign wb.wdata2_o    = wdata2_q;
  assign wb.busy_o      = |pend_v;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  rf_write_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) wb();

  rf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .DROP_ZERO(1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .wb      (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb.req_valid_i[i]         = 1'b1;
    wb.req_addr_i[i*AW +: AW] = a;
    wb.req_data_i[i*DW +: DW] = d;
  endtask

  task automatic clr_req();
    wb.req_valid_i = '0;
  endtask

  task automatic do_reset();
    clr_req();
    flush = 1'b0;
    rst   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clr_req();
    flush = 1'b0;
    rst   = 1'b1;
    tick();
    checks++; if (wb.req_ready_o !== 4'h0) begin errors++; $display("FAIL rst_ready got %0h exp 0", wb.req_ready_o); end
    checks++; if (wb.we1_o !== 1'b0 || wb.we2_o !== 1'b0) begin errors++; $display("FAIL rst_we got %0b%0b exp 00", wb.we1_o, wb.we2_o); end
    checks++; if (wb.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", wb.busy_o); end
    checks++; if (wb.waddr1_o !== 5'd0 || wb.wdata2_o !== 32'd0) begin errors++; $display("FAIL rst_addr_data got %0h/%0h exp 0/0", wb.waddr1_o, wb.wdata2_o); end
    rst = 1'b0;
    #1;
    checks++; if (wb.req_ready_o !== 4'hf) begin errors++; $display("FAIL post_rst_ready got %0h exp f", wb.req_ready_o); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 5'd5, 32'hAAAA_0001);
    tick();
    clr_req();
    checks++; if (wb.busy_o !== 1'b1 || wb.we1_o !== 1'b0) begin errors++; $display("FAIL single_n1 busy/we1 got %0b/%0b exp 1/0", wb.busy_o, wb.we1_o); end
    tick();
    checks++; if (wb.we1_o !== 1'b1 || wb.waddr1_o !== 5'd5 || wb.wdata1_o !== 32'hAAAA_0001) begin errors++; $display("FAIL single_port1 got %0b/%0h/%0h exp 1/5/aaaa0001", wb.we1_o, wb.waddr1_o, wb.wdata1_o); end
    checks++; if (wb.we2_o !== 1'b0 || wb.busy_o !== 1'b0) begin errors++; $display("FAIL single_n2 we2/busy got %0b/%0b exp 0/0", wb.we2_o, wb.busy_o); end
    tick();
    checks++; if (wb.we1_o !== 1'b0 || wb.waddr1_o !== 5'd5) begin errors++; $display("FAIL single_hold we1/waddr1 got %0b/%0h exp 0/5", wb.we1_o, wb.waddr1_o); end
  endtask

  task automatic test_four();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'(32'h100 + i));
    tick();
    clr_req();
    checks++; if (wb.req_ready_o !== 4'b0011) begin errors++; $display("FAIL four_ready_n1 got %0h exp 3", wb.req_ready_o); end
    tick();
    checks++; if (wb.we1_o !== 1'b1 || wb.waddr1_o !== 5'd1 || wb.wdata1_o !== 32'h100) begin errors++; $display("FAIL four_p1_n2 got %0b/%0h/%0h exp 1/1/100", wb.we1_o, wb.waddr1_o, wb.wdata1_o); end
    checks++; if (wb.we2_o !== 1'b1 || wb.waddr2_o !== 5'd2 || wb.wdata2_o !== 32'h101) begin errors++; $display("FAIL four_p2_n2 got %0b/%0h/%0h exp 1/2/101", wb.we2_o, wb.waddr2_o, wb.wdata2_o); end
    checks++; if (wb.req_ready_o !== 4'hf) begin errors++; $display("FAIL four_ready_n2 got %0h exp f", wb.req_ready_o); end
    tick();
    checks++; if (wb.waddr1_o !== 5'd3 || wb.waddr2_o !== 5'd4 || wb.we1_o !== 1'b1 || wb.we2_o !== 1'b1) begin errors++; $display("FAIL four_n3 got %0h/%0h exp 3/4", wb.waddr1_o, wb.waddr2_o); end
    checks++; if (wb.busy_o !== 1'b0 || wb.req_ready_o !== 4'hf) begin errors++; $display("FAIL four_idle busy/ready got %0b/%0h exp 0/f", wb.busy_o, wb.req_ready_o); end
    // Pointer back at 0: req0 must win over req3 on a shared address.
    set_req(0, 5'd6, 32'hD0);
    set_req(3, 5'd6, 32'hD3);
    tick();
    clr_req();
    tick();
    checks++; if (wb.we1_o !== 1'b1 || wb.waddr1_o !== 5'd6 || wb.wdata1_o !== 32'hD0 || wb.we2_o !== 1'b0) begin errors++; $display("FAIL four_rr_wrap got %0b/%0h/%0h we2 %0b exp 1/6/d0 we2 0", wb.we1_o, wb.waddr1_o, wb.wdata1_o, wb.we2_o); end
  endtask

  task automatic test_conflict();
    do_reset();
    set_req(1, 5'd7, 32'h11);
    set_req(2, 5'd7, 32'h22);
    tick();
    clr_req();
    checks++; if (wb.req_ready_o !== 4'b1011) begin errors++; $display("FAIL conf_ready got %0h exp b", wb.req_ready_o); end
    tick();
    checks++; if (wb.we1_o !== 1'b1 || wb.waddr1_o !== 5'd7 || wb.wdata1_o !== 32'h11 || wb.we2_o !== 1'b0) begin errors++; $display("FAIL conf_n2 got %0b/%0h/%0h we2 %0b exp 1/7/11 we2 0", wb.we1_o, wb.waddr1_o, wb.wdata1_o, wb.we2_o); end
    tick();
    checks++; if (wb.we1_o !== 1'b1 || wb.waddr1_o !== 5'd7 || wb.wdata1_o !== 32'h22 || wb.we2_o !== 1'b0) begin errors++; $display("FAIL conf_n3 got %0b/%0h/%0h we2 %0b exp 1/7/22 we2 0", wb.we1_o, wb.waddr1_o, wb.wdata1_o, wb.we2_o); end
  endtask

  task automatic test_zero_drop();
    do_reset();
    set_req(0, 5'd0, 32'h1);
    set_req(1, 5'd9, 32'h99);
    tick();
    clr_req();
    checks++; if (wb.req_ready_o !== 4'hf) begin errors++; $display("FAIL zero_ready got %0h exp f", wb.req_ready_o); end
    tick();
    checks++; if (wb.we1_o !== 1'b0) begin errors++; $display("FAIL zero_we1 got %0b exp 0", wb.we1_o); end
    checks++; if (wb.we2_o !== 1'b1 || wb.waddr2_o !== 5'd9 || wb.wdata2_o !== 32'h99) begin errors++; $display("FAIL zero_port2 got %0b/%0h/%0h exp 1/9/99", wb.we2_o, wb.waddr2_o, wb.wdata2_o); end
    checks++; if (wb.busy_o !== 1'b0) begin errors++; $display("FAIL zero_busy got %0b exp 0", wb.busy_o); end
  endtask

  task automatic test_fairness();
    int cnt[8];
    for (int a = 0; a < 8; a++) cnt[a] = 0;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'(32'h200 + i));
    tick();
    for (int c = 0; c < 100; c++) begin
      tick();
      if (wb.we1_o === 1'b1) cnt[int'(wb.waddr1_o) & 7]++;
      if (wb.we2_o === 1'b1) cnt[int'(wb.waddr2_o) & 7]++;
      checks++; if (wb.we1_o === 1'b1 && wb.we2_o === 1'b1 && wb.waddr1_o === wb.waddr2_o) begin errors++; $display("FAIL fair_dual_write cycle %0d addr %0h exp distinct", c, wb.waddr1_o); end
    end
    clr_req();
    for (int a = 1; a <= 4; a++) begin
      checks++; if (cnt[a] != 50) begin errors++; $display("FAIL fair_count addr %0d got %0d exp 50", a, cnt[a]); end
    end
  endtask

  // Three same-address entries stay pending behind one registered write.
  task automatic setup_three_pending();
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'd8, DW'(32'h80 + i));
    tick();
    clr_req();
    tick();
  endtask

  task automatic test_flush();
    setup_three_pending();
    checks++; if (wb.we1_o !== 1'b1 || wb.wdata1_o !== 32'h80 || wb.busy_o !== 1'b1) begin errors++; $display("FAIL flush_pre we1/wdata1/busy got %0b/%0h/%0b exp 1/80/1", wb.we1_o, wb.wdata1_o, wb.busy_o); end
    flush = 1'b1;
    #1;
    checks++; if (wb.req_ready_o !== 4'h0) begin errors++; $display("FAIL flush_ready got %0h exp 0", wb.req_ready_o); end
    tick();
    flush = 1'b0;
    checks++; if (wb.busy_o !== 1'b0 || wb.we1_o !== 1'b0 || wb.we2_o !== 1'b0) begin errors++; $display("FAIL flush_n1 busy/we got %0b/%0b%0b exp 0/00", wb.busy_o, wb.we1_o, wb.we2_o); end
    tick();
    checks++; if (wb.busy_o !== 1'b0 || wb.we1_o !== 1'b0 || wb.we2_o !== 1'b0) begin errors++; $display("FAIL flush_n2 busy/we got %0b/%0b%0b exp 0/00", wb.busy_o, wb.we1_o, wb.we2_o); end
  endtask

  task automatic test_reset_mid();
    setup_three_pending();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wb.we1_o !== 1'b0 || wb.we2_o !== 1'b0 || wb.busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_async we/busy got %0b%0b/%0b exp 00/0", wb.we1_o, wb.we2_o, wb.busy_o); end
    checks++; if (wb.req_ready_o !== 4'h0 || wb.waddr1_o !== 5'd0) begin errors++; $display("FAIL rstmid_ready_addr got %0h/%0h exp 0/0", wb.req_ready_o, wb.waddr1_o); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (wb.req_ready_o !== 4'hf || wb.busy_o !== 1'b0 || wb.we1_o !== 1'b0) begin errors++; $display("FAIL rstmid_after ready/busy/we1 got %0h/%0b/%0b exp f/0/0", wb.req_ready_o, wb.busy_o, wb.we1_o); end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    flush          = 1'b0;
    wb.req_valid_i = '0;
    wb.req_addr_i  = '0;
    wb.req_data_i  = '0;
    test_reset();
    test_single();
    test_four();
    test_conflict();
    test_zero_drop();
    test_fairness();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
